// File: rtl/encoder_sample_sched.sv
// encoder_sample_sched
// Decides when the encoder step counter and position are snapshotted, holds
// each snapshot behind a valid/ack handshake and reports the step delta
// between consecutive snapshots for speed estimation.
//
// Optional feature macro: ENC_SAMPLE_TIMESTAMP_EN. When defined, a free-running
// 32-bit cycle counter is latched into o_timestamp with each accepted capture.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_enable                scheduler run; 0 drains the pending sample then idles
//   i_trig_sel              00 sw only, 01 carrier low, 10 carrier high, 11 both
//   i_pwm_carrier_low/high  carrier event levels (rising edge used)
//   i_sw_trig               single-cycle capture request, bypasses decimation
//   i_decim                 capture once every decim+1 hardware triggers
//   i_counter_in            live step counter
//   i_position_in           live position
//   o_sample_valid          snapshot available, i_sample_ack accepts it
//   o_steps/o_position      captured counter/position
//   o_delta                 counter minus previous captured counter (mod 2^32)
//   o_seq                   snapshot sequence number
//   o_first                 first snapshot since enable rose (delta forced 0)
//   o_overrun, i_overrun_clr sticky dropped-capture flag and its clear
//   o_busy                  scheduler in ARMED or VALID
//
// state   | meaning
// S_IDLE  | stopped, triggers ignored
// S_ARMED | waiting for a capture event
// S_VALID | snapshot held until acknowledged
module encoder_sample_sched #(
  parameter int DECIM_W = 8,
  parameter int SEQ_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [1:0]         i_trig_sel,
  input  logic               i_pwm_carrier_low,
  input  logic               i_pwm_carrier_high,
  input  logic               i_sw_trig,
  input  logic [DECIM_W-1:0] i_decim,
  input  logic [31:0]        i_counter_in,
  input  logic [31:0]        i_position_in,
  output logic               o_sample_valid,
  input  logic               i_sample_ack,
  output logic [31:0]        o_steps,
  output logic [31:0]        o_position,
  output logic [31:0]        o_delta,
  output logic [SEQ_W-1:0]   o_seq,
  output logic               o_first,
  output logic               o_overrun,
  input  logic               i_overrun_clr,
  output logic               o_busy
`ifdef ENC_SAMPLE_TIMESTAMP_EN
  ,output logic [31:0]       o_timestamp
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_VALID = 2'd2
  } state_t;

  localparam logic [SEQ_W-1:0]   SEQ_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};
  localparam logic [DECIM_W-1:0] DCNT_ONE = {{(DECIM_W-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  logic               r_low_prev, r_high_prev;
  logic [DECIM_W-1:0] r_dcnt;
  logic [31:0]        r_prev;
  logic               r_first_pend;
  logic [31:0]        r_steps, r_position, r_delta;
  logic [SEQ_W-1:0]   r_seq;
  logic               r_first, r_overrun;

  logic w_hw_trig, w_dec_hit, w_active, w_cap, w_accept, w_drop;

  assign w_hw_trig = (i_trig_sel[0] & i_pwm_carrier_low  & ~r_low_prev) |
                     (i_trig_sel[1] & i_pwm_carrier_high & ~r_high_prev);
  assign w_dec_hit = (r_dcnt >= i_decim);
  // With enable low the scheduler only drains; no new captures are taken.
  assign w_active  = i_enable & (r_state != S_IDLE);
  assign w_cap     = w_active & (i_sw_trig | (w_hw_trig & w_dec_hit));
  assign w_accept  = w_cap & ((r_state == S_ARMED) | i_sample_ack);
  assign w_drop    = w_cap & (r_state == S_VALID) & ~i_sample_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_enable) w_state_nxt = S_ARMED;
      S_ARMED: begin
        if (!i_enable)  w_state_nxt = S_IDLE;
        else if (w_cap) w_state_nxt = S_VALID;
      end
      S_VALID: begin
        if (i_sample_ack && !w_cap) w_state_nxt = i_enable ? S_ARMED : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_low_prev   <= 1'b0;
      r_high_prev  <= 1'b0;
      r_dcnt       <= '0;
      r_prev       <= '0;
      r_first_pend <= 1'b1;
      r_steps      <= '0;
      r_position   <= 32'hFFFF_FFFF;
      r_delta      <= '0;
      r_seq        <= '0;
      r_first      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_low_prev  <= i_pwm_carrier_low;
      r_high_prev <= i_pwm_carrier_high;

      if (r_state == S_IDLE) begin
        if (i_enable) r_dcnt <= '0;
      end else if (w_active) begin
        if (i_sw_trig)      r_dcnt <= '0;
        else if (w_hw_trig) r_dcnt <= w_dec_hit ? '0 : r_dcnt + DCNT_ONE;
      end

      if (w_accept) begin
        r_steps    <= i_counter_in;
        r_position <= i_position_in;
        r_delta    <= r_first_pend ? 32'd0 : (i_counter_in - r_prev);
        r_prev     <= i_counter_in;
        r_seq      <= r_seq + SEQ_ONE;
        r_first    <= r_first_pend;
      end

      // Accept requires enable, so the set-on-disable branch never races it.
      if (!i_enable || (r_state == S_IDLE)) r_first_pend <= 1'b1;
      else if (w_accept)                    r_first_pend <= 1'b0;

      if (w_drop)             r_overrun <= 1'b1;
      else if (i_overrun_clr) r_overrun <= 1'b0;
    end
  end

`ifdef ENC_SAMPLE_TIMESTAMP_EN
  logic [31:0] r_cycle, r_timestamp;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle     <= '0;
      r_timestamp <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_accept) r_timestamp <= r_cycle;
    end
  end
  assign o_timestamp = r_timestamp;
`endif

  assign o_sample_valid = (r_state == S_VALID);
  assign o_busy         = (r_state != S_IDLE);
  assign o_steps        = r_steps;
  assign o_position     = r_position;
  assign o_delta        = r_delta;
  assign o_seq          = r_seq;
  assign o_first        = r_first;
  assign o_overrun      = r_overrun;

endmodule

// File: doc/encoder_sample_sched.md
Name: encoder_sample_sched

Overview:
Scheduler and handshake controller that decides when the quadrature encoder's step counter and single-revolution position are snapshotted. It selects the trigger source (PWM carrier low, carrier high, both, or software), decimates triggers, and computes the step delta between consecutive snapshots for speed estimation. Each snapshot is held behind a valid/ack handshake to the register/AXI layer. It sits between the encoder counter datapath and the control-code register interface.

Parameters:
DECIM_W, 8, width of decimation ratio input and internal trigger counter
SEQ_W, 16, width of snapshot sequence number

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  1 = scheduler running; 0 = stop after any pending sample drains
trig_sel  in  2  00 software only, 01 carrier low, 10 carrier high, 11 both carriers
pwm_carrier_low  in  1  carrier-low event, level; rising edge used
pwm_carrier_high  in  1  carrier-high event, level; rising edge used
sw_trig  in  1  single-cycle software capture request, bypasses decimation
decim  in  DECIM_W  capture once every decim+1 qualifying hardware triggers
counter_in  in  32  live step counter from encoder datapath
position_in  in  32  live position (0xFFFFFFFF = index not yet seen)
sample_valid  out  1  snapshot available
sample_ack  in  1  consumer accepts snapshot
steps_out  out  32  captured counter_in
position_out  out  32  captured position_in
delta_out  out  32  counter_in minus previous captured counter, mod 2^32, two's complement
seq_out  out  SEQ_W  snapshot sequence number
first_out  out  1  1 = snapshot is first since enable rose; delta_out forced 0
overrun  out  1  sticky: capture event occurred while previous sample unacknowledged
overrun_clr  in  1  clears overrun
busy  out  1  1 in ARMED or VALID

Behaviour:
- Reset values: sample_valid 0, steps_out 0, position_out 0xFFFFFFFF, delta_out 0, seq_out 0, first_out 0, overrun 0, busy 0, state IDLE, decim counter 0, carrier edge registers 0, prev counter 0, first-pending flag 1.
- Edge detect: per carrier, register previous level every cycle regardless of state; rise = level & ~prev.
- hw_trig = (trig_sel[0] & rise_low) | (trig_sel[1] & rise_high); both in one cycle count as one trigger.
- Capture event (in ARMED or VALID): sw_trig, or hw_trig with dcnt >= decim. On hw_trig: dcnt <= 0 if capture else dcnt+1. sw_trig resets dcnt to 0. Because the compare is >=, a decim reduced mid-run captures on the next trigger. Simultaneous sw_trig and hw_trig produce one capture.
- Capture latches counter_in/position_in present at that edge; sample_valid high from the next cycle (1-cycle latency). delta_out = counter_in - prev (wraps naturally); prev <= counter_in; seq_out increments and wraps at 2^SEQ_W. first_out = first-pending flag, which is cleared at capture and set whenever enable is 0.
- FSM:
  - IDLE: busy 0. When enable=1, go to ARMED, clear dcnt, and set the first-pending flag.
  - ARMED: on capture event, go to VALID. If enable=0, go to IDLE.
  - VALID: sample_valid 1; outputs stable until ack.
    - ack with no capture event: go to ARMED, or to IDLE if enable=0.
    - ack and capture event in the same cycle: latch the new sample, stay VALID, no overrun.
    - capture event without ack: drop the sample (outputs, prev and seq unchanged) and set overrun.
    - enable=0: no new captures; remain VALID until ack, then go to IDLE.
- Triggers and sw_trig are ignored in IDLE; dcnt does not advance.
- overrun: overrun_clr clears it; a set event in the same cycle as overrun_clr wins.
- rst mid-handshake: all outputs return to reset values next cycle; any pending sample is discarded.

Optional Feature:
ENC_SAMPLE_TIMESTAMP_EN defined: adds output timestamp_out [31:0] and a free-running 32-bit cycle counter (reset 0, wraps). The counter value is latched into timestamp_out with each accepted capture (reset 0). Dropped samples do not update it.
Not defined: no counter and no timestamp_out port; all other behaviour is identical.

Test Plan:
- Reset, then enable=1, trig_sel=01, decim=3, counter_in=100. Pulse carrier low 4 times. Required: exactly one sample_valid, on the cycle after the 4th rising edge; steps_out=100, first_out=1, delta_out=0, seq_out=1.
- Ack the sample, set counter_in=0x00000002 (previous 0xFFFFFFFE), sw_trig. Required: delta_out=4, first_out=0, seq_out incremented.
- trig_sel=11, decim=0, assert both carriers rising in the same cycle. Required: one capture only, seq_out +1.
- Hold sample_ack=0 and trigger twice. Required: outputs keep the first sample and overrun=1. Then assert overrun_clr together with a third trigger. Required: overrun stays 1.
- In VALID, assert sample_ack and a capture event in the same cycle. Required: new sample latched, sample_valid stays 1, overrun 0.
- With sample pending, drop enable. Required: stays VALID and ignores triggers; after ack goes IDLE with busy=0. Assert rst in VALID: next cycle sample_valid=0, position_out=0xFFFFFFFF.
